trng_ctrl: RTL

TRNG_CTRL -- requirements
Module: trng_ctrl

---
 rtl/trng_pkg.sv | 36 +++
 rtl/trng_sync2.sv | 25 ++
 rtl/trng_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG sampling controller.
package trng_pkg;

    // Controller states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WARMUP = 3'd1,
        S_SAMPLE = 3'd2,
        S_HOLD   = 3'd3,
        S_FAIL   = 3'd4
    } trng_state_e;

    // Default timing and health-test settings
    localparam int SAMPLE_DIV_DEF = 16;
    localparam int WARMUP_DEF     = 64;
    localparam int REP_LIMIT_DEF  = 32;

    // Width of the repetition counter; holds any legal limit (up to 63)
    localparam int REP_W = 6;

    // Next repetition count: a run starts at 1, grows on a repeat and
    // saturates at its maximum so it never wraps back below the limit.
    function automatic logic [REP_W-1:0] rep_step(input logic [REP_W-1:0] cnt,
                                                  input logic             same);
        logic [REP_W-1:0] res;
        if (cnt == '0 || !same) begin
            res = REP_W'(1);
        end else if (cnt == {REP_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + REP_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/trng_sync2.sv
// Two-flop synchronizer that brings the free-running oscillator output into clk.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/trng_ctrl.sv
// TRNG controller: warms up the ring oscillator, samples it, applies von
// Neumann debiasing, assembles bytes and runs a repetition-count health test.
module trng_ctrl
    import trng_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int WARMUP     = WARMUP_DEF,
    parameter int REP_LIMIT  = REP_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       ro_raw,
    output logic       ro_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       health_fail
);

    trng_state_e      state_q,  state_d;
    logic [7:0]       warm_q,   warm_d;
    logic [7:0]       div_q,    div_d;
    logic             phase_q,  phase_d;
    logic             first_q,  first_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       byte_q,   byte_d;
    logic [REP_W-1:0] rep_q,    rep_d;
    logic             prev_q,   prev_d;
    logic             hfail_q,  hfail_d;

    logic             ro_sync;
    logic [REP_W-1:0] rep_next;
    logic             trip;
    logic             bit_yield;
    logic             byte_done;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ro_raw),
        .q_o   (ro_sync)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, sample history, byte shifter and health flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_q   <= '0;
            div_q    <= '0;
            phase_q  <= 1'b0;
            first_q  <= 1'b0;
            bitcnt_q <= '0;
            byte_q   <= '0;
            rep_q    <= '0;
            prev_q   <= 1'b0;
            hfail_q  <= 1'b0;
        end else begin
            warm_q   <= warm_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
            first_q  <= first_d;
            bitcnt_q <= bitcnt_d;
            byte_q   <= byte_d;
            rep_q    <= rep_d;
            prev_q   <= prev_d;
            hfail_q  <= hfail_d;
        end
    end

    // Next-state logic: start=0 always wins, a health trip beats byte completion
    always_comb begin
        state_d   = state_q;
        warm_d    = warm_q;
        div_d     = div_q;
        phase_d   = phase_q;
        first_d   = first_q;
        bitcnt_d  = bitcnt_q;
        byte_d    = byte_q;
        rep_d     = rep_q;
        prev_d    = prev_q;
        hfail_d   = hfail_q;
        rep_next  = rep_step(rep_q, ro_sync == prev_q);
        trip      = 1'b0;
        bit_yield = 1'b0;
        byte_done = 1'b0;

        if (!start) begin
            state_d  = S_IDLE;
            warm_d   = '0;
            div_d    = '0;
            phase_d  = 1'b0;
            bitcnt_d = '0;
            byte_d   = '0;
            rep_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_WARMUP;
                    warm_d  = '0;
                    hfail_d = 1'b0;
                end
                S_WARMUP: begin
                    if (warm_q == 8'(WARMUP - 1)) begin
                        state_d  = S_SAMPLE;
                        div_d    = '0;
                        phase_d  = 1'b0;
                        bitcnt_d = '0;
                        byte_d   = '0;
                        rep_d    = '0;
                    end else begin
                        warm_d = warm_q + 8'd1;
                    end
                end
                S_SAMPLE: begin
                    if (div_q == 8'(SAMPLE_DIV - 1)) begin
                        div_d  = '0;
                        prev_d = ro_sync;
                        rep_d  = rep_next;
                        trip   = (rep_next >= REP_W'(REP_LIMIT));
                        if (!phase_q) begin
                            first_d = ro_sync;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            // 10 -> 1, 01 -> 0: the yielded bit equals the first sample
                            if (first_q != ro_sync) begin
                                bit_yield = 1'b1;
                                byte_d    = {byte_q[6:0], first_q};
                                bitcnt_d  = bitcnt_q + 3'd1;
                                byte_done = (bitcnt_q == 3'd7);
                            end
                        end
                        if (trip) begin
                            state_d  = S_FAIL;
                            hfail_d  = 1'b1;
                            byte_d   = '0;
                            bitcnt_d = '0;
                            phase_d  = 1'b0;
                        end else if (bit_yield && byte_done) begin
                            state_d = S_HOLD;
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                S_HOLD: begin
                    // Repetition history is kept across the handshake
                    if (rd_ready) begin
                        state_d  = S_SAMPLE;
                        bitcnt_d = '0;
                        phase_d  = 1'b0;
                        div_d    = '0;
                        byte_d   = '0;
                    end
                end
                S_FAIL: begin
                    hfail_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign ro_en       = (state_q == S_WARMUP) || (state_q == S_SAMPLE) || (state_q == S_HOLD);
    assign rd_valid    = (state_q == S_HOLD);
    assign rd_data     = (state_q == S_HOLD) ? byte_q : 8'h00;
    assign health_fail = hfail_q;

endmodule
